// File: rtl/psdsquare_seq.sv
// psdsquare_seq: sequential unsigned squarer.
// Radix-2 shift-add multiplier squaring xin over exactly NBITSIN clock cycles.
// A start pulse in IDLE captures xin. The result lands in sq and done pulses once.
module psdsquare_seq #(
  parameter int NBITSIN = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NBITSIN-1:0]     xin,
  output logic                   busy,
  output logic                   done,
  output logic [2*NBITSIN-1:0]   sq
);

  localparam int RW = 2 * NBITSIN;
  localparam int CW = $clog2(NBITSIN) + 1;

  // The counter value that marks the step about to complete the product.
  localparam logic [CW-1:0] LAST_STEP = CW'(NBITSIN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state;
  logic [RW-1:0]       mcand;
  logic [NBITSIN-1:0]  mplier;
  logic [RW-1:0]       acc;
  logic [CW-1:0]       cnt;

  logic [RW-1:0]       acc_next;
  logic [CW-1:0]       cnt_next;
  logic                last_step;

  // Compute the next accumulator value and detect the final step.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    acc_next  = acc;
    cnt_next  = cnt + CW'(1);
    last_step = (cnt == LAST_STEP);
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  assign busy = (state == RUN);

  // Sequencer: capture the operand, step the shift-add datapath, and publish the result.
  always_ff @(posedge clock) begin
    // NOTE: all state here uses non-blocking assignments. Every register then
    // samples pre-edge values, and the datapath registers update together.
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sq     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{NBITSIN{1'b0}}, xin};
            mplier <= xin;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt_next;
          if (last_step) begin
            sq    <= acc_next;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psdsquare_seq.sv
// Directed testbench for psdsquare_seq with the default 16-bit operand width.
module tb_psdsquare_seq;

  localparam int W = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  xin;
  logic          busy;
  logic          done;
  logic [2*W-1:0] sq;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] last_sq = '0;

  psdsquare_seq #(.NBITSIN(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .xin   (xin),
    .busy  (busy),
    .done  (done),
    .sq    (sq)
  );

  always #5 clock = ~clock;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one square, then follow every edge until the result edge.
  // If poke_at > 0, a stray start with xin=0x0100 is raised after that RUN edge.
  task automatic run_op(input logic [W-1:0] x, input logic [2*W-1:0] exp,
                        input int poke_at, input string tag);
    start = 1'b1;
    xin   = x;
    step();
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    check({tag, " no done after start"}, 64'(done), 64'd0);
    start = 1'b0;
    xin   = ~x;
    for (int i = 1; i <= W; i++) begin
      step();
      if (i < W) begin
        if (busy !== 1'b1 || done !== 1'b0) begin
          check({tag, " busy/done mid-run"}, {62'd0, busy, done}, 64'b10);
        end
        if (i == W / 2) begin
          check({tag, " sq holds mid-run"}, 64'(sq), 64'(last_sq));
        end
      end else begin
        check({tag, " done at result edge"}, 64'(done), 64'd1);
        check({tag, " busy low at done"}, 64'(busy), 64'd0);
        check({tag, " sq"}, 64'(sq), 64'(exp));
        last_sq = exp;
      end
      if (poke_at > 0 && i == poke_at) begin
        start = 1'b1;
        xin   = 16'h0100;
      end else if (poke_at > 0 && i == poke_at + 1) begin
        start = 1'b0;
      end
    end
  endtask

  // Idle for n edges. done must stay low and sq must hold.
  task automatic idle_quiet(input int n, input string tag);
    int pulses = 0;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check({tag, " no stray done"}, 64'(pulses), 64'd0);
    check({tag, " sq holds idle"}, 64'(sq), 64'(last_sq));
  endtask

  initial begin
    logic [W-1:0] rx;
    int pulses;

    reset = 1'b1;
    start = 1'b1;
    xin   = 16'hABCD;
    step();
    step();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sq", 64'(sq), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    step();
    check("idle after reset busy", 64'(busy), 64'd0);

    run_op(16'h0003, 32'h00000009, 0, "basic");
    step();
    check("basic done one cycle", 64'(done), 64'd0);
    idle_quiet(3, "basic");

    run_op(16'h0000, 32'h00000000, 0, "zero");
    run_op(16'hFFFF, 32'hFFFE0001, 0, "max");
    idle_quiet(2, "max");

    // Back-to-back: the second start is raised in the done cycle of the first.
    run_op(16'h00B5, 32'h00007FF9, 0, "b2b first");
    run_op(16'h1234, 32'h014B5A90, 0, "b2b second");
    idle_quiet(2, "b2b");

    // Start while busy is ignored. The stray start arrives after the 4th RUN edge.
    run_op(16'h0002, 32'h00000004, 4, "busy start");
    idle_quiet(20, "busy start");

    // Reset in the middle of an operation.
    start = 1'b1;
    xin   = 16'h00FF;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("pre-abort busy", 64'(busy), 64'd1);
    reset = 1'b1;
    start = 1'b1;
    step();
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort sq", 64'(sq), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    last_sq = '0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    check("abort no done", 64'(pulses), 64'd0);
    check("abort sq stays 0", 64'(sq), 64'd0);
    run_op(16'h000A, 32'h00000064, 0, "after abort");

    // A few random operands, each checked against a product computed in the bench.
    for (int n = 0; n < 8; n++) begin
      rx = W'($urandom);
      run_op(rx, 32'(rx) * 32'(rx), 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psdsquare_seq.md
PSDSQUARE_SEQ -- requirements
Module: psdsquare_seq

Interface
REQ-001 SHALL have parameter NBITSIN, default 16, operand width in bits; result width is 2*NBITSIN.
REQ-002 SHALL have port clock  input  1  master clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle pulse requesting a new square.
REQ-005 SHALL have port xin  input  NBITSIN  operand, unsigned integer.
REQ-006 SHALL have port busy  output  1  high while an operation is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse, sq holds a new result.
REQ-008 SHALL have port sq  output  2*NBITSIN  xin*xin, unsigned, registered.

Function
REQ-009 SHALL implement FSM states IDLE and RUN; state is IDLE after reset.
REQ-010 In IDLE, start=1 at edge k SHALL capture xin into multiplicand reg (zero-extended to 2*NBITSIN) and multiplier reg, clear accumulator and iteration counter, and enter RUN.
REQ-011 In IDLE with start=0, all registers SHALL hold.
REQ-012 Each RUN edge SHALL perform one radix-2 shift-add step: if multiplier LSB=1, acc <= acc + multiplicand; multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-013 Accumulator additions SHALL be 2*NBITSIN bits wide; no overflow is possible and none SHALL be flagged.
REQ-014 Iteration count SHALL be fixed at NBITSIN steps regardless of operand value (no early termination).
REQ-015 On the NBITSIN-th RUN edge (edge k+NBITSIN) sq SHALL load the accumulator value including that final step, done SHALL be 1 for exactly the following cycle, and state SHALL return to IDLE.
REQ-016 Latency SHALL be NBITSIN cycles from start-sampling edge to result edge (16 for default).
REQ-017 busy SHALL equal (state==RUN): high in the cycles after edge k through edge k+NBITSIN, low in the cycle done is high.
REQ-018 start asserted while busy=1 SHALL be ignored; operation, xin capture and sq SHALL be unaffected.
REQ-019 start asserted in the cycle done=1 SHALL be accepted (back-to-back operation, no dead cycle).
REQ-020 xin SHALL be sampled only at the accepting edge; later xin changes SHALL not affect the result.
REQ-021 sq SHALL hold its last value between completions, including during a subsequent RUN.
REQ-022 done SHALL be 0 in all cycles other than the one defined in REQ-015.
REQ-023 Counter width SHALL be clog2(NBITSIN)+1 bits.

Reset
REQ-024 reset=1 at any edge SHALL force state IDLE, busy=0, done=0, sq=0, and clear accumulator, multiplicand, multiplier and counter.
REQ-025 reset SHALL take priority over start and over an in-progress RUN; an aborted operation SHALL produce no done pulse and no sq update.
REQ-026 After reset deasserts, the first start SHALL behave exactly as REQ-010.

Verification
REQ-027 Basic: xin=16'h0003, start pulse -> after 16 cycles done=1, sq=32'h00000009; busy high for 16 cycles.
REQ-028 Extremes: xin=16'h0000 -> sq=32'h00000000 with done; xin=16'hFFFF -> sq=32'hFFFE0001 with done.
REQ-029 Back-to-back: xin=16'h00B5 then start in done cycle with xin=16'h1234 -> sq=32'h00007FF9, then 16 cycles later sq=32'h014B5A90; two done pulses exactly 16 cycles apart.
REQ-030 Busy start: xin=16'h0002 start, then start with xin=16'h0100 at cycle 5 -> single done at cycle 16, sq=32'h00000004.
REQ-031 Reset mid-op: xin=16'h00FF start, reset at cycle 8 -> sq=0, busy=0, no done pulse; new start xin=16'h000A -> sq=32'h00000064 after 16 cycles.
REQ-032 Random: 10k random xin, sq compared with reference xin*xin; also checked against psdsqrt_xtra round trip (sqrt(sq)==xin).
